// File: rtl/csr_hpm_pkg.sv
// Shared CSR address constants and helpers for the hardware performance
// monitor: address map, parameter legality, and ovf_o slot numbering.
package csr_hpm_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT0    = 12'h320;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

    localparam int unsigned CNT_LO_W = 32;

    function automatic logic params_ok(int unsigned hpm, int unsigned w,
                                       int unsigned ev);
        return hpm <= 29 && w >= 33 && w <= 64 && ev >= 1 && ev <= 32;
    endfunction

    // ovf_o bit i belongs to counter CSR number slot_num(i):
    // bit0 mcycle, bit1 minstret, bit k+2 mhpmcounter(k+3)
    function automatic int unsigned slot_num(int unsigned slot);
        return (slot == 0) ? 0 : slot + 1;
    endfunction

    function automatic logic [31:0] inhibit_mask(int unsigned hpm);
        logic [31:0] m;
        m = 32'h5;
        for (int unsigned b = 3; b < hpm + 3; b++) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic csr_hit(logic [11:0] a);
        logic [6:0] blk;
        logic [4:0] n;
        blk = a[11:5];
        n   = a[4:0];
        return blk == 7'h58 || blk == 7'h5C || blk == 7'h60 ||
               blk == 7'h64 || (blk == 7'h19 && n != 5'd1 && n != 5'd2);
    endfunction

endpackage

// File: rtl/csr_hpm_counter.sv
// One performance counter: increment, split-half load, sticky wrap flag.
// A write in the same cycle as an increment wins and clears the flag.
module csr_hpm_counter
    import csr_hpm_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         we_lo,
    input  logic         we_hi,
    input  logic [31:0]  wdata,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (we_lo || we_hi) begin
            if (we_lo) cnt[CNT_LO_W-1:0] <= wdata;
            if (we_hi) cnt[W-1:CNT_LO_W] <= wdata[W-CNT_LO_W-1:0];
            ovf <= 1'b0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
            if (&cnt) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/csr_hpm.sv
// Machine/user performance counters: mcycle, minstret, mhpmcounterN,
// mhpmeventN selectors and mcountinhibit, with sticky wrap flags.
module csr_hpm
    import csr_hpm_pkg::*;
#(
    parameter int unsigned HPM_NUM   = 4,
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned EVENT_NUM = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 csr_we_i,
    input  logic [11:0]          csr_waddr_i,
    input  logic [31:0]          csr_wdata_i,
    input  logic [11:0]          csr_raddr_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_hit_o,
    input  logic                 instr_retire_i,
    input  logic [EVENT_NUM-1:0] event_i,
    input  logic                 count_stop_i,
    output logic [HPM_NUM+1:0]   ovf_o
);

    localparam int unsigned CNT = HPM_NUM + 2;
    localparam logic [31:0] INH_MASK = inhibit_mask(HPM_NUM);

    if (!params_ok(HPM_NUM, CNT_WIDTH, EVENT_NUM)) begin : g_bad_params
        $error("csr_hpm: parameter out of legal range");
    end

    logic [31:0]          inhibit_q;
    logic [CNT-1:0][31:0] rd_part;

    always_ff @(posedge clk) begin
        if (rst) begin
            inhibit_q <= '0;
        end else if (csr_we_i && csr_waddr_i == CSR_MCOUNTINHIBIT) begin
            inhibit_q <= csr_wdata_i & INH_MASK;
        end
    end

    for (genvar i = 0; i < CNT; i++) begin : g_slot
        localparam int unsigned N = slot_num(i);
        localparam logic [11:0] A = 12'(N);

        logic                 ev;
        logic                 inc;
        logic                 we_lo;
        logic                 we_hi;
        logic                 ovf;
        logic [CNT_WIDTH-1:0] cnt;
        logic [63:0]          cnt_ext;
        logic [31:0]          evt_word;
        logic [31:0]          rd;

        if (i == 0) begin : g_cycle
            assign ev       = 1'b1;
            assign evt_word = '0;
        end else if (i == 1) begin : g_instret
            assign ev       = instr_retire_i;
            assign evt_word = '0;
        end else begin : g_hpm
            logic [EVENT_NUM-1:0] evt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    evt_q <= '0;
                end else if (csr_we_i &&
                             csr_waddr_i == CSR_MHPMEVENT0 + A) begin
                    evt_q <= csr_wdata_i[EVENT_NUM-1:0];
                end
            end

            // Several selected events in one cycle still count once
            assign ev       = |(event_i & evt_q);
            assign evt_word = (csr_raddr_i == CSR_MHPMEVENT0 + A) ?
                              32'(evt_q) : '0;
        end

        assign inc   = ev && !inhibit_q[N] && !count_stop_i;
        assign we_lo = csr_we_i && csr_waddr_i == CSR_MCYCLE + A;
        assign we_hi = csr_we_i && csr_waddr_i == CSR_MCYCLEH + A;

        csr_hpm_counter #(
            .W (CNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc),
            .we_lo (we_lo),
            .we_hi (we_hi),
            .wdata (csr_wdata_i),
            .cnt   (cnt),
            .ovf   (ovf)
        );

        assign cnt_ext = 64'(cnt);

        always_comb begin
            rd = evt_word;
            unique case (1'b1)
                csr_raddr_i == CSR_MCYCLE + A,
                csr_raddr_i == CSR_CYCLE + A:  rd = cnt_ext[31:0];
                csr_raddr_i == CSR_MCYCLEH + A,
                csr_raddr_i == CSR_CYCLEH + A: rd = cnt_ext[63:32];
                default: ;
            endcase
        end

        assign rd_part[i] = rd;
        assign ovf_o[i]   = ovf;
    end

    always_comb begin
        csr_rdata_o = (csr_raddr_i == CSR_MCOUNTINHIBIT) ? inhibit_q : '0;
        for (int unsigned i = 0; i < CNT; i++) begin
            csr_rdata_o = csr_rdata_o | rd_part[i];
        end
    end

    assign csr_hit_o = csr_hit(csr_raddr_i);

endmodule
